// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - capture FIFO for 5-bit ALU results with sticky overflow status
//
// Purpose: stores each accepted ALU result (F, Overflow, Cout, opcode) in a
// small first-word-fall-through FIFO with valid/ready handshakes on both sides,
// and keeps a sticky overflow flag across the whole run.
//
// Optional feature: define SATURATE_EN to saturate F on add/sub overflow.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               write handshake (in_ready = !full)
//   in_f, in_ovf, in_cout, in_op    ALU result fields to store
//   out_valid/out_ready             read handshake (out_valid = !empty)
//   out_f, out_ovf, out_cout, out_op head entry fields, zero when empty
//   count, full, empty              occupancy status
//   ovf_sticky, clr_sticky          sticky overflow flag and its sync clear
`timescale 1ns/1ps
module alu_result_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_f,
    input  logic          in_ovf,
    input  logic          in_cout,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_f,
    output logic          out_ovf,
    output logic          out_cout,
    output logic [1:0]    out_op,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_sticky,
    input  logic          clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = W + 4;

    // Entry layout: {f, ovf, cout, op}
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;
    logic          push, pop;
    logic [W-1:0]  f_store;
    logic [EW-1:0] head;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = count_q;
    assign ovf_sticky = sticky_q;

    // A full FIFO refuses writes even when a pop frees a slot this cycle.
    assign push = in_valid & ~full;
    assign pop  = out_ready & ~empty;

`ifdef SATURATE_EN
    // Add/sub overflow clamps toward the true result's sign: a negative-looking
    // wrapped result came from a positive overflow, and vice versa.
    always_comb begin
        f_store = in_f;
        if (in_ovf && !in_op[1]) begin
            f_store = in_f[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    assign f_store = in_f;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        // DEPTH is a power of two, so pointers wrap naturally.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set beats clear when both occur together.
        if (clr_sticky)       sticky_d = 1'b0;
        if (push && in_ovf)   sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is intentionally not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {f_store, in_ovf, in_cout, in_op};
    end

    assign head = mem_q[rd_ptr_q];

    // First-word fall-through, gated to zero while empty.
    always_comb begin
        out_f    = '0;
        out_ovf  = 1'b0;
        out_cout = 1'b0;
        out_op   = 2'b00;
        if (!empty) begin
            out_f    = head[EW-1 -: W];
            out_ovf  = head[3];
            out_cout = head[2];
            out_op   = head[1:0];
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - self-checking bench for alu_result_fifo
`timescale 1ns/1ps
module tb_alu_result_fifo;

    localparam int W = 5;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ovf, in_cout, out_ready, clr_sticky;
    logic [W-1:0]  in_f;
    logic [1:0]    in_op;
    logic          in_ready, out_valid, out_ovf, out_cout, full, empty, ovf_sticky;
    logic [W-1:0]  out_f;
    logic [1:0]    out_op;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    alu_result_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_ovf(in_ovf), .in_cout(in_cout), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_ovf(out_ovf), .out_cout(out_cout), .out_op(out_op),
        .count(count), .full(full), .empty(empty),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    typedef struct {
        logic [W-1:0] f;
        logic         ovf;
        logic         cout;
        logic [1:0]   op;
    } entry_t;

    typedef struct {
        logic         v;
        logic [W-1:0] f;
        logic         ovf;
        logic         cout;
        logic [1:0]   op;
        logic         rdy;
        logic         clr;
        int           e_count;
        logic         e_valid;
        logic [W-1:0] e_f;
        logic         e_full;
    } vec_t;

    entry_t mq[$];
    logic   m_sticky;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stored F as the spec's rules define it.
    function automatic logic [W-1:0] model_f(input logic [W-1:0] f, input logic ovf, input logic [1:0] op);
        logic [W-1:0] r;
        r = f;
`ifdef SATURATE_EN
        if (ovf && op < 2) r = f[W-1] ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
`endif
        return r;
    endfunction

    task automatic compare_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".in_ready"}, int'(in_ready), int'(n != DEPTH));
        chk({tag, ".out_valid"}, int'(out_valid), int'(n != 0));
        chk({tag, ".sticky"}, int'(ovf_sticky), int'(m_sticky));
        if (n != 0) begin
            chk({tag, ".out_f"}, int'(out_f), int'(mq[0].f));
            chk({tag, ".out_ovf"}, int'(out_ovf), int'(mq[0].ovf));
            chk({tag, ".out_cout"}, int'(out_cout), int'(mq[0].cout));
            chk({tag, ".out_op"}, int'(out_op), int'(mq[0].op));
        end else begin
            chk({tag, ".out_zero"}, int'({out_f, out_ovf, out_cout, out_op}), 0);
        end
    endtask

    // Drive inputs, advance one clock, update the model and compare.
    task automatic step(input logic v, input logic [W-1:0] f, input logic ovf, input logic cout,
                        input logic [1:0] op, input logic rdy, input logic clr, input string tag);
        bit p, q;
        entry_t e;
        in_valid = v; in_f = f; in_ovf = ovf; in_cout = cout; in_op = op;
        out_ready = rdy; clr_sticky = clr;
        p = v && (mq.size() < DEPTH);
        q = rdy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (q) void'(mq.pop_front());
        if (p) begin
            e.f = model_f(f, ovf, op); e.ovf = ovf; e.cout = cout; e.op = op;
            mq.push_back(e);
        end
        if (clr) m_sticky = 1'b0;
        if (p && ovf) m_sticky = 1'b1;
        compare_model(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++)
            step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, "drain");
    endtask

    vec_t vecs[9];
    logic [W-1:0] sat_exp;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_f = '0; in_ovf = 0; in_cout = 0; in_op = 2'b00;
        out_ready = 0; clr_sticky = 0;
        mq.delete();
        m_sticky = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("reset.count", int'(count), 0);
        chk("reset.empty", int'(empty), 1);
        chk("reset.full", int'(full), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.sticky", int'(ovf_sticky), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single push 7+7, then pop
        step(1'b1, 5'b01110, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "single.push");
        chk("single.out_f", int'(out_f), 5'b01110);
        chk("single.count", int'(count), 1);
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, "single.pop");
        chk("single.empty", int'(empty), 1);

        // Fill/order table: 4 pushes, ignored 5th push with coincident pop, drain, pop on empty
        vecs[0] = '{1, 5'd1, 0, 1, 2'b01, 0, 0, 1, 1, 5'd1, 0};
        vecs[1] = '{1, 5'd2, 0, 0, 2'b00, 0, 0, 2, 1, 5'd1, 0};
        vecs[2] = '{1, 5'd3, 0, 1, 2'b11, 0, 0, 3, 1, 5'd1, 0};
        vecs[3] = '{1, 5'd4, 0, 0, 2'b10, 0, 0, 4, 1, 5'd1, 1};
        vecs[4] = '{1, 5'd31, 0, 0, 2'b00, 1, 0, 3, 1, 5'd2, 0};
        vecs[5] = '{0, 5'd0, 0, 0, 2'b00, 1, 0, 2, 1, 5'd3, 0};
        vecs[6] = '{0, 5'd0, 0, 0, 2'b00, 1, 0, 1, 1, 5'd4, 0};
        vecs[7] = '{0, 5'd0, 0, 0, 2'b00, 1, 0, 0, 0, 5'd0, 0};
        vecs[8] = '{0, 5'd0, 0, 0, 2'b00, 1, 0, 0, 0, 5'd0, 0};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].f, vecs[i].ovf, vecs[i].cout, vecs[i].op,
                 vecs[i].rdy, vecs[i].clr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.count", i), int'(count), vecs[i].e_count);
            chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(vecs[i].e_valid));
            chk($sformatf("tbl%0d.f", i), int'(out_f), int'(vecs[i].e_f));
            chk($sformatf("tbl%0d.full", i), int'(full), int'(vecs[i].e_full));
        end

        // Push+pop at count 2 across several pointer wraps
        step(1'b1, 5'd10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "pp.fill0");
        step(1'b1, 5'd11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "pp.fill1");
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, W'(12 + i), 1'b0, 1'(i), 2'(i), 1'b1, 1'b0, "pp.both");
            chk("pp.count", int'(count), 2);
        end
        drain();

        // Overflow path 15+7
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "ovf.clr0");
`ifdef SATURATE_EN
        sat_exp = 5'b01111;
`else
        sat_exp = 5'b10110;
`endif
        step(1'b1, 5'b10110, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "ovf.push");
        chk("ovf.sticky", int'(ovf_sticky), 1);
        chk("ovf.out_f", int'(out_f), int'(sat_exp));
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, "ovf.clr");
        chk("ovf.clr_alone", int'(ovf_sticky), 0);
        step(1'b1, 5'b01001, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, "ovf.clr_set");
        chk("ovf.set_wins", int'(ovf_sticky), 1);
        drain();

        // Logic op with ovf flag is never saturated
        step(1'b1, 5'b01111, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "logic.push");
        chk("logic.out_f", int'(out_f), 5'b01111);
        drain();

        // Asynchronous reset mid-operation
        step(1'b1, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "ar.push0");
        step(1'b1, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "ar.push1");
        in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.count", int'(count), 0);
        chk("ar.out_valid", int'(out_valid), 0);
        chk("ar.empty", int'(empty), 1);
        chk("ar.sticky", int'(ovf_sticky), 0);
        mq.delete();
        m_sticky = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1'b1, 5'd7, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, "ar.first");
        chk("ar.first_count", int'(count), 1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
